rf_wport_arbiter: RTL and testbench
===================================

// Module: rf_wport_arbiter
// PURPOSE
//  Shares the single GPR-file write port between the W pipeline stage and one
//  auxiliary late-result source, such as the multi-cycle mult/div unit.
//  W always has priority. Aux results go into a small FIFO and are written in
//  cycles where W does not write. A wait counter forces a pipeline stall so aux
//  results cannot starve. A pending-lookup port lets the D-stage hazard unit
//  stall on registers that still have a write in flight.
// PARAMETERS
//  DEPTH     2   aux FIFO entries (power of 2, >=2)
//  MAX_WAIT  8   cycles a non-empty FIFO may go undrained before stall_req
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low (0 = reset)
//  w_we       in   1   W-stage RegWrite
//  w_a3       in   5   W-stage destination register
//  w_wd       in   32  W-stage write data
//  aux_valid  in   1   aux result offered
//  aux_a3     in   5   aux destination register
//  aux_wd     in   32  aux write data
//  aux_ready  out  1   aux result accepted this cycle when aux_valid=1
//  q_a1       in   5   hazard query reg (rs)
//  q_a2       in   5   hazard query reg (rt)
//  q_hit1     out  1   q_a1!=0 and matches a valid FIFO entry
//  q_hit2     out  1   q_a2!=0 and matches a valid FIFO entry
//  stall_req  out  1   core must present W idle (w_we=0) from the next cycle on
//  rf_we      out  1   GPR write enable
//  rf_a3      out  5   GPR write address
//  rf_wd      out  32  GPR write data
//  rf_src     out  1   0 = W wrote, 1 = aux FIFO head wrote
// BEHAVIOUR
//  Reset: FIFO empty, wait_cnt=0, state=NORM.
//   Outputs during reset: aux_ready=1, stall_req=0, rf_we=0, q_hit*=0.
//  W is idle when w_we=0 or w_a3==0.
//  Write mux is combinational:
//   - W not idle: rf_we=1, a3/wd from W, rf_src=0.
//   - Else if FIFO non-empty: head is written (rf_src=1) and popped at the edge.
//   - Else: rf_we=0, rf_a3=0, rf_wd=0.
//  aux_ready = !full, from registered state only.
//   - A push into a full FIFO is never accepted, even if that cycle pops.
//   - aux_valid=1 with aux_a3==0: handshake completes, entry discarded, no push.
//  Latency: an accepted aux entry is written no earlier than the next cycle.
//   - There is no same-cycle bypass to the write port.
//  Push and pop in the same cycle are both legal; count stays unchanged.
//  Aux entries are written in FIFO order. Pointers wrap mod DEPTH.
//  q_hit* compares against all valid entries, including an entry being pushed
//   this cycle. The hazard unit stalls D while hit=1.
//  wait_cnt ($clog2(MAX_WAIT+1) bits):
//   - Clears on pop or when the FIFO is empty.
//   - Otherwise increments, saturating at MAX_WAIT.
//  FSM NORM -> FORCE when wait_cnt==MAX_WAIT and the FIFO is non-empty.
//  FORCE: stall_req=1.
//   - Returns to NORM on the cycle after the first pop; wait_cnt then restarts.
//   - If W still writes while in FORCE, W keeps priority; stay in FORCE.
//  stall_req is registered (state-decoded) and is 0 in NORM.
//  Reset mid-operation: all pending aux entries are lost. Aux must reissue.
// TESTING
//  1 W writes r8=0x11 with FIFO empty
//    -> rf_we=1, a3=8, wd=0x11, src=0 in the same cycle.
//  2 aux r9=0xAA accepted at cycle t, W idle at t+1
//    -> rf_we=1, a3=9, wd=0xAA, src=1 at t+1; FIFO empty at t+2.
//  3 two aux pushes while W writes every cycle
//    -> aux_ready=0 on the third offer.
//    -> stall_req=1 after 8 undrained cycles.
//    -> with W idled, entries drain in order; stall_req=0 after the first pop.
//  4 aux r5 pending, q_a1=5, q_a2=0
//    -> q_hit1=1, q_hit2=0. After drain, q_hit1=0.
//  5 aux_a3=0 offered -> aux_ready=1, FIFO count unchanged, no rf write.
//  6 reset asserted with 2 entries queued
//    -> immediately rf_we=0, stall_req=0, aux_ready=1.
//    -> after release, W-idle cycles give no aux writes.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// GPR write-port arbiter: W stage has priority; aux results queue in a small FIFO
// and drain in W-idle cycles, with a starvation guard that requests a W stall.
module rf_wport_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_we,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_wd,
  input  logic        aux_valid,
  input  logic [4:0]  aux_a3,
  input  logic [31:0] aux_wd,
  output logic        aux_ready,
  input  logic [4:0]  q_a1,
  input  logic [4:0]  q_a2,
  output logic        q_hit1,
  output logic        q_hit2,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic        rf_src
);

  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  typedef enum logic [0:0] {
    NORM  = 1'b0,
    FORCE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        a3_q [DEPTH];
  logic [31:0]       wd_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [WW-1:0]     wait_q, wait_d;

  logic act;
  logic w_act;
  logic empty;
  logic full;
  logic push;
  logic pop;

  // Registered flags are already cleared while reset is low; 'act' also
  // masks the combinational W path so nothing is written during reset.
  assign act   = reset;
  assign w_act = w_we && (w_a3 != 5'd0);
  assign empty = ~|vld_q;
  assign full  = &vld_q;

  assign aux_ready = !full;
  assign push      = act && aux_valid && !full && (aux_a3 != 5'd0);
  assign pop       = act && !w_act && !empty;
  assign stall_req = (state_q == FORCE);

  always_comb begin
    rf_we  = 1'b0;
    rf_a3  = 5'd0;
    rf_wd  = 32'd0;
    rf_src = 1'b0;
    if (act && w_act) begin
      rf_we = 1'b1;
      rf_a3 = w_a3;
      rf_wd = w_wd;
    end else if (pop) begin
      rf_we  = 1'b1;
      rf_a3  = a3_q[rd_q];
      rf_wd  = wd_q[rd_q];
      rf_src = 1'b1;
    end
  end

  always_comb begin
    q_hit1 = act && push && (aux_a3 == q_a1);
    q_hit2 = act && push && (aux_a3 == q_a2);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (a3_q[i] == q_a1)) q_hit1 = act;
      if (vld_q[i] && (a3_q[i] == q_a2)) q_hit2 = act;
    end
    if (q_a1 == 5'd0) q_hit1 = 1'b0;
    if (q_a2 == 5'd0) q_hit2 = 1'b0;
  end

  always_comb begin
    vld_d = vld_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (pop) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = rd_q + PW'(1);
    end
    if (push) begin
      vld_d[wr_q] = 1'b1;
      wr_d        = wr_q + PW'(1);
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (pop || empty) begin
      wait_d = '0;
    end else if (wait_q != WMAX) begin
      wait_d = wait_q + WW'(1);
    end
  end

  // Entry is skipped when the head is draining this very cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORM:  if ((wait_q == WMAX) && !empty && !pop) state_d = FORCE;
      FORCE: if (pop) state_d = NORM;
      default: state_d = NORM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NORM;
      vld_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        a3_q[i] <= 5'd0;
        wd_q[i] <= 32'd0;
      end
    end else if (push) begin
      a3_q[wr_q] <= aux_a3;
      wd_q[wr_q] <= aux_wd;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed scenarios then random traffic
// against a queue-based reference model.
module tb_rf_wport_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic        aux_valid;
  logic [4:0]  aux_a3;
  logic [31:0] aux_wd;
  logic        aux_ready;
  logic [4:0]  q_a1;
  logic [4:0]  q_a2;
  logic        q_hit1;
  logic        q_hit2;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        rf_src;

  rf_wport_arbiter #(
    .DEPTH(DEPTH),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .w_we(w_we),
    .w_a3(w_a3),
    .w_wd(w_wd),
    .aux_valid(aux_valid),
    .aux_a3(aux_a3),
    .aux_wd(aux_wd),
    .aux_ready(aux_ready),
    .q_a1(q_a1),
    .q_a2(q_a2),
    .q_hit1(q_hit1),
    .q_hit2(q_hit2),
    .stall_req(stall_req),
    .rf_we(rf_we),
    .rf_a3(rf_a3),
    .rf_wd(rf_wd),
    .rf_src(rf_src)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
  } ent_t;

  ent_t mq[$];
  int   mwait;
  bit   mfrc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [4:0] a3,
                     input logic [31:0] wd, input logic av,
                     input logic [4:0] aa3, input logic [31:0] awd,
                     input logic [4:0] q1, input logic [4:0] q2);
    bit widle, rdy, push, pop, ne;
    bit h1, h2;
    logic e_we, e_src;
    logic [4:0] e_a3;
    logic [31:0] e_wd;
    ent_t e;
    @(negedge clk);
    w_we = we; w_a3 = a3; w_wd = wd;
    aux_valid = av; aux_a3 = aux_a3_f(aa3); aux_wd = awd;
    q_a1 = q1; q_a2 = q2;
    #1;
    widle = !we || (a3 == 5'd0);
    ne    = mq.size() > 0;
    rdy   = mq.size() < DEPTH;
    push  = av && rdy && (aa3 != 5'd0);
    pop   = widle && ne;
    e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0; e_src = 1'b0;
    if (!widle) begin
      e_we = 1'b1; e_a3 = a3; e_wd = wd;
    end else if (ne) begin
      e_we = 1'b1; e_a3 = mq[0].a3; e_wd = mq[0].wd; e_src = 1'b1;
    end
    h1 = push && (aa3 == q1);
    h2 = push && (aa3 == q2);
    foreach (mq[i]) begin
      if (mq[i].a3 == q1) h1 = 1'b1;
      if (mq[i].a3 == q2) h2 = 1'b1;
    end
    if (q1 == 5'd0) h1 = 1'b0;
    if (q2 == 5'd0) h2 = 1'b0;
    chk("rf_we", 32'(rf_we), 32'(e_we));
    if (e_we) begin
      chk("rf_a3", 32'(rf_a3), 32'(e_a3));
      chk("rf_wd", rf_wd, e_wd);
      chk("rf_src", 32'(rf_src), 32'(e_src));
    end
    chk("aux_ready", 32'(aux_ready), 32'(rdy));
    chk("q_hit1", 32'(q_hit1), 32'(h1));
    chk("q_hit2", 32'(q_hit2), 32'(h2));
    chk("stall_req", 32'(stall_req), 32'(mfrc));
    if (!mfrc) begin
      if (mwait == MAX_WAIT && ne && !pop) mfrc = 1'b1;
    end else if (pop) begin
      mfrc = 1'b0;
    end
    if (pop || !ne) mwait = 0;
    else if (mwait < MAX_WAIT) mwait++;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.a3 = aa3; e.wd = awd;
      mq.push_back(e);
    end
  endtask

  function automatic logic [4:0] aux_a3_f(input logic [4:0] v);
    return v;
  endfunction

  task automatic idle(input logic [4:0] q1);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, 5'd0);
  endtask

  initial begin
    reset = 1'b0;
    w_we = 1'b0; w_a3 = 5'd0; w_wd = 32'd0;
    aux_valid = 1'b0; aux_a3 = 5'd0; aux_wd = 32'd0;
    q_a1 = 5'd0; q_a2 = 5'd0;
    mwait = 0; mfrc = 1'b0;
    #12;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_ready", 32'(aux_ready), 32'd1);
    chk("rst_hit1", 32'(q_hit1), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // W write with empty FIFO
    cyc(1'b1, 5'd8, 32'h11, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("t1_a3", 32'(rf_a3), 32'd8);

    // aux accepted, written next cycle
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAA, 5'd0, 5'd0);
    chk("t2_nobypass", 32'(rf_we), 32'd0);
    idle(5'd9);
    chk("t2_src", 32'(rf_src), 32'd1);
    idle(5'd9);

    // FIFO fill under continuous W, starvation guard, ordered drain
    for (int i = 0; i < 12; i++)
      cyc(1'b1, 5'(1 + i), 32'(i), 1'b1, 5'(20 + i), 32'(32'hB0 + i),
          5'd20, 5'd21);
    chk("t3_stall", 32'(stall_req), 32'd1);
    cyc(1'b1, 5'd2, 32'h5, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) idle(5'd20);
    chk("t3_stall_off", 32'(stall_req), 32'd0);

    // pending lookup incl. same-cycle push
    cyc(1'b1, 5'd1, 32'd1, 1'b1, 5'd5, 32'h55, 5'd5, 5'd0);
    cyc(1'b1, 5'd1, 32'd2, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(5'd5);
    idle(5'd5);

    // aux to r0 is swallowed
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd0);
    idle(5'd0);

    // reset with two entries queued
    cyc(1'b1, 5'd4, 32'd4, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0);
    cyc(1'b1, 5'd4, 32'd5, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    w_we = 1'b1; w_a3 = 5'd3; aux_valid = 1'b1; aux_a3 = 5'd6;
    q_a1 = 5'd6; q_a2 = 5'd7;
    #1;
    chk("t6_rf_we", 32'(rf_we), 32'd0);
    chk("t6_stall", 32'(stall_req), 32'd0);
    chk("t6_ready", 32'(aux_ready), 32'd1);
    chk("t6_hit1", 32'(q_hit1), 32'd0);
    mq.delete(); mwait = 0; mfrc = 1'b0;
    @(negedge clk);
    w_we = 1'b0; aux_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) idle(5'd6);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      logic we, av;
      logic [4:0] a3, aa3, q1, q2;
      we  = ($urandom_range(0, 1) == 1);
      if (mfrc && $urandom_range(0, 9) != 0) we = 1'b0;
      a3  = 5'($urandom_range(0, 31));
      av  = ($urandom_range(0, 2) != 0);
      aa3 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      q1  = 5'($urandom_range(0, 31));
      q2  = 5'($urandom_range(0, 31));
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) q1 = mq[0].a3;
      if ($urandom_range(0, 3) == 0) q2 = aa3;
      cyc(we, a3, 32'($urandom), av, aa3, 32'($urandom), q1, q2);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
